// File: rtl/clear_ctrl_pkg.sv
// Shared board geometry, FSM state encoding and scoring constants for the line-clear sequencer.
package clear_ctrl_pkg;

   // Board geometry: row r occupies bits [r*BOARD_W +: BOARD_W]; row 0 is the top row.
   localparam int BOARD_W    = 10;
   localparam int BOARD_H    = 20;
   localparam int BOARD_SIZE = BOARD_W * BOARD_H;
   localparam int CLEAR_LEN  = 3;

   typedef enum logic [2:0] {
      CC_IDLE     = 3'd0,
      CC_DETECT   = 3'd1,
      CC_FLASH    = 3'd2,
      CC_PASS     = 3'd3,
      CC_PASS_CHK = 3'd4,
      CC_SCORE    = 3'd5,
      CC_DONE     = 3'd6
   } cc_state_t;

   // Points per request for 1..4 cleared lines, before the level multiplier.
   localparam logic [10:0] SCORE_1 = 11'd40;
   localparam logic [10:0] SCORE_2 = 11'd100;
   localparam logic [10:0] SCORE_3 = 11'd300;
   localparam logic [10:0] SCORE_4 = 11'd1200;

   // Base score for a request; counts above four are paid as four.
   function automatic logic [10:0] score_base(input logic [4:0] cnt);
      logic [10:0] base;
      case (cnt)
         5'd0:    base = 11'd0;
         5'd1:    base = SCORE_1;
         5'd2:    base = SCORE_2;
         5'd3:    base = SCORE_3;
         default: base = SCORE_4;
      endcase
      return base;
   endfunction

endpackage

// File: rtl/clear_ctrl_flash.sv
// Flash phase timer: phase starts "on", toggles every FLASH_HALF cycles while enabled,
// and flags the last cycle of FLASH_N on/off pairs.
module clear_ctrl_flash #(
   parameter logic [11:0] FLASH_HALF = 12'd6,
   parameter logic [2:0]  FLASH_N    = 3'd3
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic phase,
   output logic expired
);

   localparam logic [3:0] TOGGLES = {FLASH_N, 1'b0};

   logic [11:0] half_reg;
   logic [3:0]  toggle_reg;
   logic        phase_reg;
   logic        half_end;

   assign half_end = (half_reg == FLASH_HALF - 12'd1);
   assign phase    = phase_reg;
   assign expired  = en && half_end && (toggle_reg == TOGGLES - 4'd1);

   // Half-period counter with phase toggle; clear re-arms it with the phase "on".
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         half_reg   <= 12'd0;
         toggle_reg <= 4'd0;
         phase_reg  <= 1'b1;
      end else if (en) begin
         if (half_end) begin
            half_reg   <= 12'd0;
            toggle_reg <= toggle_reg + 4'd1;
            phase_reg  <= ~phase_reg;
         end else begin
            half_reg <= half_reg + 12'd1;
         end
      end
   end

endmodule

// File: rtl/clear_ctrl.sv
// Line-clear sequencer: latches the locked board, flashes full rows, drives the external
// clear unit until no full row remains, then writes the board back and updates scoring.
module clear_ctrl
   import clear_ctrl_pkg::*;
#(
   parameter logic [11:0] FLASH_HALF = 12'd6,
   parameter logic [2:0]  FLASH_N    = 3'd3,
   parameter int          SCORE_W    = 20,
   parameter int          LINES_W    = 10,
   parameter int          MAX_PASS   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BOARD_SIZE-1:0] board_in,
   output logic                  busy,
   output logic                  done,
   output logic [BOARD_SIZE-1:0] board_out,
   output logic                  board_we,
   output logic [BOARD_H-1:0]    flash_rows,
   output logic [BOARD_SIZE-1:0] clr_board,
   input  logic [CLEAR_LEN-1:0]  clr_num,
   input  logic [BOARD_SIZE-1:0] clr_next,
   output logic [LINES_W-1:0]    lines_total,
   output logic [3:0]            level,
   output logic [SCORE_W-1:0]    score
);

   localparam int               PW        = SCORE_W + 5;
   localparam logic [2:0]       PASS_LIM  = 3'(MAX_PASS);
   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
   localparam logic [LINES_W-1:0] LINES_MAX = {LINES_W{1'b1}};

   cc_state_t             state_reg, state_next;
   logic [BOARD_SIZE-1:0] work_reg;
   logic [4:0]            cnt_reg;
   logic [2:0]            pass_reg;
   logic [SCORE_W-1:0]    score_reg;
   logic [LINES_W-1:0]    lines_reg;
   logic [3:0]            level_reg;
   logic [BOARD_H-1:0]    full_mask;
   logic                  phase;
   logic                  flash_expired;

   // Full-row detection on the registered working board.
   for (genvar gi = 0; gi < BOARD_H; gi++) begin : g_row
      assign full_mask[gi] = &work_reg[gi*BOARD_W +: BOARD_W];
   end

   clear_ctrl_flash #(
      .FLASH_HALF (FLASH_HALF),
      .FLASH_N    (FLASH_N)
   ) u_flash (
      .clk     (clk),
      .rst     (rst),
      .clear   (state_reg == CC_DETECT),
      .en      (state_reg == CC_FLASH),
      .phase   (phase),
      .expired (flash_expired)
   );

   // Scoring arithmetic: product is wide enough never to wrap, then saturating adds.
   logic [PW-1:0]      prod;
   logic [PW:0]        score_sum;
   logic [SCORE_W-1:0] score_sat;
   logic [LINES_W:0]   lines_sum;
   logic [LINES_W-1:0] lines_sat;
   logic [LINES_W-1:0] tens;
   logic [3:0]         level_calc;

   assign prod       = PW'(score_base(cnt_reg)) * (PW'(level_reg) + PW'(1));
   assign score_sum  = {1'b0, prod} + (PW+1)'(score_reg);
   assign score_sat  = (score_sum > (PW+1)'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
   assign lines_sum  = (LINES_W+1)'(lines_reg) + (LINES_W+1)'(cnt_reg);
   assign lines_sat  = lines_sum[LINES_W] ? LINES_MAX : lines_sum[LINES_W-1:0];
   assign tens       = lines_reg / LINES_W'(10);
   assign level_calc = (tens > LINES_W'(15)) ? 4'd15 : tens[3:0];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= CC_IDLE;
      else     state_reg <= state_next;
   end

   // Next-state logic. An empty request still passes through SCORE (adding zero) so the
   // no-clear latency is a fixed three cycles.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         CC_IDLE:     if (start) state_next = CC_DETECT;
         CC_DETECT:   state_next = (full_mask == '0) ? CC_SCORE : CC_FLASH;
         CC_FLASH:    if (flash_expired) state_next = CC_PASS;
         CC_PASS:     state_next = CC_PASS_CHK;
         CC_PASS_CHK: state_next = (clr_num == '0 || pass_reg == PASS_LIM) ? CC_SCORE : CC_PASS;
         CC_SCORE:    state_next = CC_DONE;
         CC_DONE:     state_next = CC_IDLE;
         default:     state_next = CC_IDLE;
      endcase
   end

   // Datapath: working board, pass/line counters and the persistent score state.
   always_ff @(posedge clk) begin
      if (rst) begin
         work_reg  <= '0;
         cnt_reg   <= 5'd0;
         pass_reg  <= 3'd0;
         score_reg <= '0;
         lines_reg <= '0;
         level_reg <= 4'd0;
      end else begin
         level_reg <= level_calc;
         case (state_reg)
            CC_IDLE: if (start) work_reg <= board_in;
            CC_DETECT: begin
               cnt_reg  <= 5'd0;
               pass_reg <= 3'd0;
            end
            CC_PASS: begin
               work_reg <= clr_next;
               cnt_reg  <= cnt_reg + 5'(clr_num);
               pass_reg <= pass_reg + 3'd1;
            end
            CC_SCORE: begin
               score_reg <= score_sat;
               lines_reg <= lines_sat;
            end
            default: ;
         endcase
      end
   end

   assign busy        = (state_reg != CC_IDLE);
   assign done        = (state_reg == CC_DONE);
   assign board_we    = done && (cnt_reg != 5'd0);
   assign flash_rows  = (state_reg == CC_FLASH && phase) ? full_mask : '0;
   assign board_out   = work_reg;
   assign clr_board   = work_reg;
   assign lines_total = lines_reg;
   assign level       = level_reg;
   assign score       = score_reg;

endmodule

// File: tb/tb_clear_ctrl.sv
// Bench for clear_ctrl: behavioural clear unit, request-level model and per-cycle compare.
module tb_clear_ctrl;
   import clear_ctrl_pkg::*;

   localparam int FH = 6;
   localparam int FN = 3;

   logic                  clk = 1'b0;
   logic                  rst, start, busy, done, board_we;
   logic [BOARD_SIZE-1:0] board_in, board_out, clr_board, clr_next;
   logic [BOARD_H-1:0]    flash_rows;
   logic [CLEAR_LEN-1:0]  clr_num;
   logic [9:0]            lines_total;
   logic [3:0]            level;
   logic [19:0]           score;

   always #5 clk = ~clk;

   clear_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .board_in(board_in), .busy(busy), .done(done),
      .board_out(board_out), .board_we(board_we), .flash_rows(flash_rows),
      .clr_board(clr_board), .clr_num(clr_num), .clr_next(clr_next),
      .lines_total(lines_total), .level(level), .score(score)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [19:0] full_rows(input logic [199:0] bd);
      logic [19:0] m;
      for (int r = 0; r < 20; r++) m[r] = &bd[r*10 +: 10];
      return m;
   endfunction

   // Clear unit: removes the run (up to 4) of full rows starting at the lowest full row.
   function automatic logic [202:0] clear_unit(input logic [199:0] bd);
      logic [199:0] nx;
      int b;
      int run;
      b = -1;
      for (int r = 19; r >= 0; r--) if (b < 0 && (&bd[r*10 +: 10])) b = r;
      run = 0;
      if (b >= 0)
         for (int r = b; r >= 0 && r > b - 4; r--)
            if (run == b - r && (&bd[r*10 +: 10])) run++;
      nx = bd;
      if (run > 0)
         for (int r = b; r >= 0; r--)
            nx[r*10 +: 10] = (r - run >= 0) ? bd[(r-run)*10 +: 10] : 10'd0;
      return {run[2:0], nx};
   endfunction

   always_comb begin
      {clr_num, clr_next} = clear_unit(clr_board);
   end

   function automatic logic [199:0] setrow(input logic [199:0] bd, input int r, input logic [9:0] v);
      logic [199:0] o;
      o = bd;
      o[r*10 +: 10] = v;
      return o;
   endfunction

   // Request-level model state.
   int            m_score = 0, m_lines = 0, m_level = 0;
   int            exp_lat, exp_cnt, exp_score, exp_lines, exp_level;
   logic [199:0]  exp_board;
   logic [19:0]   exp_mask;
   logic          active = 1'b0;
   int            cur_t = 0;

   task automatic model(input logic [199:0] bd);
      logic [202:0] r;
      int p, base;
      exp_board = bd;
      exp_mask  = full_rows(bd);
      exp_cnt   = 0;
      p         = 0;
      if (exp_mask != 0) begin
         for (int k = 0; k < 4; k++) begin
            r = clear_unit(exp_board);
            if (r[202:200] == 0) break;
            exp_board = r[199:0];
            exp_cnt  += int'(r[202:200]);
            p++;
         end
      end
      exp_lat = (exp_mask == 0) ? 3 : 2 + 2*FN*FH + 2*p + 1;
      case (exp_cnt)
         0: base = 0;
         1: base = 40;
         2: base = 100;
         3: base = 300;
         default: base = 1200;
      endcase
      m_score = m_score + base * (m_level + 1);
      if (m_score > 1048575) m_score = 1048575;
      m_lines = m_lines + exp_cnt;
      if (m_lines > 1023) m_lines = 1023;
      m_level = (m_lines / 10 > 15) ? 15 : m_lines / 10;
      exp_score = m_score;
      exp_lines = m_lines;
      exp_level = m_level;
   endtask

   // Per-cycle compare against the timeline implied by the model.
   always @(negedge clk) begin
      if (active) begin
         logic [19:0] ef;
         ef = (exp_mask != 0 && cur_t >= 2 && cur_t <= 1 + 2*FN*FH && ((cur_t-2)/FH) % 2 == 0)
              ? exp_mask : 20'd0;
         chk($sformatf("busy t=%0d", cur_t), 256'(busy), 256'(cur_t >= 1 && cur_t <= exp_lat));
         chk($sformatf("done t=%0d", cur_t), 256'(done), 256'(cur_t == exp_lat));
         chk($sformatf("board_we t=%0d", cur_t), 256'(board_we), 256'(cur_t == exp_lat && exp_cnt != 0));
         chk($sformatf("flash_rows t=%0d", cur_t), 256'(flash_rows), 256'(ef));
         if (cur_t == exp_lat) begin
            chk("board_out", 256'(board_out), 256'(exp_board));
            chk("score", 256'(score), 256'(exp_score));
            chk("lines_total", 256'(lines_total), 256'(exp_lines));
         end
         if (cur_t == exp_lat + 1) chk("level", 256'(level), 256'(exp_level));
      end
   end

   logic [199:0] junk;

   // One request; poke re-asserts start mid-flight and coincident with done (both ignored).
   task automatic run_req(input logic [199:0] bd, input bit poke);
      model(bd);
      @(posedge clk); #1;
      board_in = bd; start = 1'b1; cur_t = 0; active = 1'b1;
      for (int i = 1; i <= exp_lat + 1; i++) begin
         @(posedge clk); #1;
         cur_t    = i;
         start    = poke && (i == 4 || i == exp_lat);
         board_in = poke ? junk : bd;
      end
      @(posedge clk); #1;
      active = 1'b0; start = 1'b0;
      $display("req lat=%0d cnt=%0d score=%0d lines=%0d level=%0d", exp_lat, exp_cnt, score, lines_total, level);
   endtask

   logic [199:0] b, b1;

   initial begin
      rst = 1'b1; start = 1'b0; board_in = '0; junk = '1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", 256'(busy), 256'(0));
      chk("rst done", 256'(done), 256'(0));
      chk("rst board_we", 256'(board_we), 256'(0));
      chk("rst flash", 256'(flash_rows), 256'(0));
      chk("rst board_out", 256'(board_out), 256'(0));
      chk("rst score", 256'(score), 256'(0));
      chk("rst lines", 256'(lines_total), 256'(0));
      chk("rst level", 256'(level), 256'(0));
      rst = 1'b0;

      // No full rows.
      b = setrow('0, 19, 10'h3FE); b = setrow(b, 18, 10'h001);
      run_req(b, 1'b0);
      chk("t1 board", 256'(board_out), 256'(b));
      chk("t1 score", 256'(score), 256'(0));

      // Single bottom row.
      b1 = setrow('0, 19, 10'h3FF); b1 = setrow(b1, 18, 10'h003); b1 = setrow(b1, 17, 10'h200);
      run_req(b1, 1'b0);
      chk("t2 row19", 256'(board_out[190 +: 10]), 256'(10'h003));
      chk("t2 row18", 256'(board_out[180 +: 10]), 256'(10'h200));
      chk("t2 score", 256'(score), 256'(40));

      // Four contiguous rows.
      b = '0;
      for (int r = 16; r < 20; r++) b = setrow(b, r, 10'h3FF);
      b = setrow(b, 15, 10'h155);
      run_req(b, 1'b0);
      chk("t3 row19", 256'(board_out[190 +: 10]), 256'(10'h155));
      chk("t3 score", 256'(score), 256'(1240));

      // Gap: rows 19 and 17, with ignored start pulses.
      b = setrow('0, 19, 10'h3FF); b = setrow(b, 18, 10'h1FF);
      b = setrow(b, 17, 10'h3FF); b = setrow(b, 16, 10'h007);
      run_req(b, 1'b1);
      chk("t4 score", 256'(score), 256'(1340));
      chk("t4 level", 256'(level), 256'(0));

      // Lines 7 -> 9 -> 10 (level 1) -> 11 with doubled payout.
      b = setrow('0, 19, 10'h3FF); b = setrow(b, 18, 10'h3FF); b = setrow(b, 17, 10'h00F);
      run_req(b, 1'b0);
      run_req(b1, 1'b0);
      chk("t5 level", 256'(level), 256'(1));
      chk("t5 lines", 256'(lines_total), 256'(10));
      run_req(b1, 1'b0);
      chk("t5 score", 256'(score), 256'(1560));

      // Five separated rows: pass limit leaves one full row behind.
      b = '0;
      for (int r = 11; r < 20; r++) b = setrow(b, r, (r % 2 == 1) ? 10'h3FF : 10'h001);
      run_req(b, 1'b0);
      chk("t6 score", 256'(score), 256'(3960));
      chk("t6 row15", 256'(board_out[150 +: 10]), 256'(10'h3FF));
      chk("t6 lines", 256'(lines_total), 256'(15));

      // Reset during FLASH.
      @(posedge clk); #1;
      board_in = b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("mid flash busy", 256'(busy), 256'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("post-rst busy", 256'(busy), 256'(0));
      chk("post-rst score", 256'(score), 256'(0));
      chk("post-rst lines", 256'(lines_total), 256'(0));
      chk("post-rst level", 256'(level), 256'(0));
      chk("post-rst flash", 256'(flash_rows), 256'(0));
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         chk("post-rst done/we", 256'({done, board_we, busy}), 256'(0));
      end
      m_score = 0; m_lines = 0; m_level = 0;
      run_req(b1, 1'b0);
      chk("t7 score", 256'(score), 256'(40));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
